// File: rtl/keypad_scan_if.sv
// keypad_scan_if: keypad matrix lines and decoded key outputs of keypad_scan
interface keypad_scan_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] button_data;
    logic       key_valid;
    logic       key_down;
    modport master (input row_in, output col_out, button_data, key_valid, key_down);
    modport slave  (output row_in, input col_out, button_data, key_valid, key_down);
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low keypad scanner with frame debounce and release FSM
module keypad_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    keypad_scan_if.master  kp
);
    localparam int            SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SLOT_MAX = SW'(SCAN_DIV - 1);
    localparam logic [3:0]    DB       = 4'(DEBOUNCE_SCANS);
    typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_t;
    typedef enum logic {ST_UP, ST_DOWN} state_t;
    logic [3:0]    r_sync1, r_sync2;
    logic [SW-1:0] r_slot;
    logic [1:0]    r_col;
    logic [3:0]    r_col_out;
    logic [15:0]   r_map;
    cls_t          r_cand_cls;
    logic [3:0]    r_cand_code;
    logic [3:0]    r_cnt;
    state_t        r_state;
    logic [3:0]    r_button;
    logic          r_valid, r_down;
    logic          w_tick, w_frame_end, w_stable;
    logic [15:0]   w_map;
    logic [4:0]    w_ones;
    logic [3:0]    w_code, w_cls_code;
    cls_t          w_cls;
    state_t        w_state_nxt;
    logic [3:0]    w_button_nxt;
    logic          w_valid_nxt, w_down_nxt;
    assign w_tick      = r_slot == SLOT_MAX;
    assign w_frame_end = w_tick && r_col == 2'd3;
    assign w_stable    = r_cnt == DB;
    // two-flop synchroniser for the asynchronous row lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= kp.row_in;
            r_sync2 <= r_sync1;
        end
    end
    // current column's samples merged into the running pressed map
    always_comb begin
        w_map = r_map;
        for (int r = 0; r < 4; r++) w_map[4*r + int'(r_col)] = ~r_sync2[r];
    end
    // classify the completed map: count set bits and remember the set index
    always_comb begin
        w_ones = '0;
        w_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (w_map[i]) begin
                w_ones = w_ones + 5'd1;
                w_code = 4'(i);
            end
        end
        w_cls      = (w_ones == 5'd0) ? CLS_NONE : (w_ones == 5'd1) ? CLS_SINGLE : CLS_MULTI;
        w_cls_code = (w_cls == CLS_SINGLE) ? w_code : 4'd0;
    end
    // slot counter, column ring and snapshot capture at each column's last cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot    <= '0;
            r_col     <= 2'd0;
            r_col_out <= 4'b1110;
            r_map     <= '0;
        end else if (w_tick) begin
            r_slot    <= '0;
            r_col     <= r_col + 2'd1;
            r_col_out <= {r_col_out[2:0], r_col_out[3]};
            r_map     <= w_map;
        end else begin
            r_slot    <= r_slot + 1'b1;
        end
    end
    // frame-level debounce: count consecutive identical classifications
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand_cls  <= CLS_NONE;
            r_cand_code <= 4'd0;
            r_cnt       <= 4'd0;
        end else if (w_frame_end) begin
            if (w_cls == r_cand_cls && w_cls_code == r_cand_code) begin
                r_cnt <= (r_cnt == DB) ? r_cnt : r_cnt + 4'd1;
            end else begin
                r_cand_cls  <= w_cls;
                r_cand_code <= w_cls_code;
                r_cnt       <= 4'd1;
            end
        end
    end
    // release FSM: accept a stable single key in UP, wait for stable NONE in DOWN
    always_comb begin
        w_state_nxt  = r_state;
        w_button_nxt = r_button;
        w_valid_nxt  = 1'b0;
        w_down_nxt   = r_down;
        if (r_state == ST_UP && w_stable && r_cand_cls == CLS_SINGLE) begin
            w_state_nxt  = ST_DOWN;
            w_button_nxt = r_cand_code;
            w_valid_nxt  = 1'b1;
            w_down_nxt   = 1'b1;
        end else if (r_state == ST_DOWN && w_stable && r_cand_cls == CLS_NONE) begin
            w_state_nxt = ST_UP;
            w_down_nxt  = 1'b0;
        end
    end
    // FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_UP;
            r_button <= 4'd0;
            r_valid  <= 1'b0;
            r_down   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_button <= w_button_nxt;
            r_valid  <= w_valid_nxt;
            r_down   <= w_down_nxt;
        end
    end
    assign kp.col_out     = r_col_out;
    assign kp.button_data = r_button;
    assign kp.key_valid   = r_valid;
    assign kp.key_down    = r_down;
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed checks of keypad_scan with an ideal key-matrix model
module tb_keypad_scan;
    localparam int LAT = (3 + 1) * 16 + 3;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pressed = 16'h0;
    int          checks = 0;
    int          failures = 0;
    int          hi_cnt = 0;
    int          p0;
    bit          found;
    keypad_scan_if kif ();
    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (.clk(clk), .rst_n(rst_n), .kp(kif.master));
    always #5 clk = ~clk;
    // a row reads low when a pressed key sits on a column being driven low
    assign kif.row_in = {~|(pressed[15:12] & ~kif.col_out), ~|(pressed[11:8] & ~kif.col_out),
                         ~|(pressed[7:4] & ~kif.col_out), ~|(pressed[3:0] & ~kif.col_out)};
    // counts every cycle key_valid is high, so each accepted press must add exactly one
    always @(negedge clk) if (kif.key_valid) hi_cnt <= hi_cnt + 1;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wait_pulse(input int budget, output bit f);
        f = 1'b0;
        for (int i = 0; i < budget && !f; i++) begin
            @(posedge clk);
            #1;
            if (kif.key_valid) f = 1'b1;
        end
    endtask
    initial begin
        // 1: reset values and column ring timing
        cyc(3);
        chk("rst_col", kif.col_out, 4'b1110);
        chk("rst_bd", kif.button_data, 4'd0);
        chk("rst_kv", kif.key_valid, 1'b0);
        chk("rst_kd", kif.key_down, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3);
        chk("ring_hold", kif.col_out, 4'b1110);
        cyc(1);
        chk("ring_step", kif.col_out, 4'b1101);
        cyc(12);
        chk("ring_wrap", kif.col_out, 4'b1110);
        // 2: clean press of key 6 (row 1, col 2)
        p0 = hi_cnt;
        pressed[6] = 1'b1;
        wait_pulse(LAT + 3, found);
        chk("press6_found", found, 1'b1);
        chk("press6_bd", kif.button_data, 4'd6);
        chk("press6_kd", kif.key_down, 1'b1);
        cyc(100);
        chk("press6_once", hi_cnt - p0, 1);
        chk("press6_held", kif.key_down, 1'b1);
        pressed = 16'h0;
        cyc(LAT + 3);
        chk("rel6_kd", kif.key_down, 1'b0);
        chk("rel6_nopulse", hi_cnt - p0, 1);
        chk("rel6_bd", kif.button_data, 4'd6);
        // 3: key 9 bouncing every 20 cycles, then held
        p0 = hi_cnt;
        for (int i = 0; i < 4; i++) begin
            pressed[9] = ~pressed[9];
            cyc(20);
        end
        chk("bounce_nopulse", hi_cnt - p0, 0);
        pressed[9] = 1'b1;
        wait_pulse(LAT + 3, found);
        chk("bounce_found", found, 1'b1);
        chk("bounce_bd", kif.button_data, 4'd9);
        pressed = 16'h0;
        cyc(LAT + 3);
        chk("bounce_rel_kd", kif.key_down, 1'b0);
        chk("bounce_once", hi_cnt - p0, 1);
        // 4: rollover 3 -> 3+5 -> 5 -> none -> 5
        pressed[3] = 1'b1;
        wait_pulse(LAT + 3, found);
        chk("roll3_found", found, 1'b1);
        chk("roll3_bd", kif.button_data, 4'd3);
        cyc(2);
        p0 = hi_cnt;
        pressed[5] = 1'b1;
        cyc(80);
        chk("multi_nopulse", hi_cnt - p0, 0);
        chk("multi_bd", kif.button_data, 4'd3);
        pressed[3] = 1'b0;
        cyc(80);
        chk("roll5_nopulse", hi_cnt - p0, 0);
        chk("roll5_bd", kif.button_data, 4'd3);
        chk("roll5_kd", kif.key_down, 1'b1);
        pressed = 16'h0;
        cyc(LAT + 3);
        chk("rollrel_kd", kif.key_down, 1'b0);
        pressed[5] = 1'b1;
        wait_pulse(LAT + 3, found);
        chk("press5_found", found, 1'b1);
        chk("press5_bd", kif.button_data, 4'd5);
        pressed = 16'h0;
        cyc(LAT + 3);
        chk("rel5_kd", kif.key_down, 1'b0);
        // 5: key 0 glitch of two frames
        p0 = hi_cnt;
        pressed[0] = 1'b1;
        cyc(32);
        pressed[0] = 1'b0;
        cyc(100);
        chk("glitch_nopulse", hi_cnt - p0, 0);
        chk("glitch_bd", kif.button_data, 4'd5);
        chk("glitch_kd", kif.key_down, 1'b0);
        // 6: reset mid-frame with key 12 held
        pressed[12] = 1'b1;
        wait_pulse(LAT + 3, found);
        chk("press12_found", found, 1'b1);
        chk("press12_bd", kif.button_data, 4'd12);
        cyc(7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_col", kif.col_out, 4'b1110);
        chk("mid_rst_bd", kif.button_data, 4'd0);
        chk("mid_rst_kv", kif.key_valid, 1'b0);
        chk("mid_rst_kd", kif.key_down, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_pulse(LAT, found);
        chk("again12_found", found, 1'b1);
        chk("again12_bd", kif.button_data, 4'd12);
        chk("again12_kd", kif.key_down, 1'b1);
        pressed = 16'h0;
        cyc(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 active-low matrix keypad, debounces it and produces the 4-bit key code consumed by the seven-segment digit decoder. It sits directly upstream of that decoder: `button_data` feeds the decoder's data input unchanged. Codes 0–9 display as digits; 10–15 are valid codes that the decoder shows as 0. A one-cycle `key_valid` strobe marks each new accepted press for other consumers.

## Interface
- `SCAN_DIV`, default 50000: clk cycles per column slot; minimum 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical frame classifications needed before a change is accepted; range 1–15.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset. Assertion is asynchronous; the block leaves reset on a clk edge after release.
- `row_in` in 4: keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col_out` out 4: column drive, active-low, exactly one bit low at a time.
- `button_data` out 4: code of the last accepted key; holds its value until the next accepted press.
- `key_valid` out 1: one-cycle pulse when a new key is accepted.
- `key_down` out 1: high while the accepted key is held, low after an accepted release.

## Operation
- **Row synchronisation:** `row_in` passes through a 2-flop synchroniser. All row references below use the synchronised value.
- **Column ring:**
  - `col_out` steps through 1110, 1101, 1011, 0111, then wraps.
  - A slot counter runs 0..SCAN_DIV-1.
  - On the edge where the slot counter equals SCAN_DIV-1, the block samples the rows for the current column, then advances the column.
- **Snapshot:**
  - The four samples form a 16-bit pressed map. Bit index is `4*row + col`, and a bit is 1 when that key is pressed.
  - A frame ends at the sample taken for column 3.
- **Frame classification:**
  - NONE: zero bits set.
  - SINGLE(code): exactly one bit set; code = `4*row + col`.
  - MULTI: two or more bits set.
- **Debounce:**
  - The block holds a candidate classification and a counter `cnt`.
  - At each frame end, if the classification equals the candidate, `cnt` increments, saturating at DEBOUNCE_SCANS.
  - Otherwise the candidate becomes the new classification and `cnt` becomes 1.
  - The candidate is stable when `cnt` equals DEBOUNCE_SCANS.
- **Release FSM, state UP (reset state):**
  - When SINGLE(c) becomes stable, the block sets `button_data`←c, pulses `key_valid` and sets `key_down`←1, then goes to DOWN.
  - A stable MULTI is ignored; the FSM stays in UP.
- **Release FSM, state DOWN:**
  - Only a stable NONE is acted on: `key_down`←0 and the FSM goes to UP.
  - A stable SINGLE with a different code, or a stable MULTI, is ignored.
  - A second key is therefore never reported without an intervening debounced release.
- **Multiple presses:** never produce `key_valid`. `button_data` is unchanged by MULTI.
- **Reset values:** `col_out`=1110, `button_data`=0, `key_valid`=0, `key_down`=0, slot counter=0, synchroniser flops=1111, candidate=NONE, `cnt`=0, state UP.

## Timing
- All outputs are registered.
- The frame period F is 4*SCAN_DIV cycles.
- **Event timing:** `key_valid`, the `button_data` update and the `key_down` rise occur on the clk edge after the frame-end edge at which `cnt` reaches DEBOUNCE_SCANS. `key_valid` is high for exactly that one cycle. The `key_down` fall follows the same rule.
- **Worst-case latency:** from a clean press to `key_valid` is (DEBOUNCE_SCANS+1)*F + 3 cycles.
- **Settling:** a row must be stable for at least 3 cycles before its sample edge to be seen. With SCAN_DIV ≥ 4, a column change always settles before its sample.
- **Reset mid-frame:** the partial snapshot is discarded. Debounce restarts from NONE. A key held through reset is reported again once stable.
- **Bounce:** any classification change within a frame sequence restarts `cnt` at 1. A press shorter than DEBOUNCE_SCANS frames produces no output.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3 (F=16).

1. **Reset:** `rst_n` low, then released → `col_out`=1110, `button_data`=0, `key_valid`=0, `key_down`=0. `col_out` steps 1110→1101 four cycles after release and wraps to 1110 after 16 cycles.
2. **Clean press:** the model closes row 1, col 2 and holds it for 10 frames → exactly one `key_valid` pulse, `button_data`=6, `key_down`=1 until release. After release and 3 frames with no key, `key_down`=0 and no pulse occurs.
3. **Bounce:** key 9 (row 2, col 1) toggles every 20 cycles for 5 frames, then holds → no `key_valid` during the bounce. One pulse with `button_data`=9 follows 3 stable frames later.
4. **Rollover and multiple keys:**
   - Press key 3, then add key 5 while 3 is held → `button_data` stays 3 with no new pulse.
   - Release 3 while 5 stays held → still no pulse (DOWN waits for NONE).
   - Release all, then press 5 → pulse with `button_data`=5.
5. **Short glitch:** key 0 pressed for 2 frames only → no `key_valid`, `button_data` keeps its previous value.
6. **Reset mid-operation:** key 12 held, with `rst_n` pulsed low mid-frame after acceptance → outputs return to reset values immediately. `key_valid` fires again with `button_data`=12 within (3+1)*16+3 cycles of release.
